// File: rtl/silu_pkg.sv
// Shared widths and FP32->BF16 narrowing for the SiLU write-back path.
// SILU_PACK_RNE_EN selects round-to-nearest-even; otherwise lanes are truncated.
package silu_pkg;

    localparam int FP32_W = 32;
    localparam int BF16_W = 16;
    localparam int LANES  = 4;
    localparam logic [FP32_W-1:0] FP32_ONE = 32'h3F800000;

    function automatic logic [BF16_W-1:0] fp32_to_bf16(input logic [FP32_W-1:0] f);
`ifdef SILU_PACK_RNE_EN
        logic [FP32_W-1:0] r;
        if (f[30:23] == 8'hFF) begin
            // Inf passes through; any NaN payload becomes a quiet NaN
            fp32_to_bf16 = BF16_W'(f >> 16);
            if (f[22:0] != 23'd0) begin
                fp32_to_bf16[6] = 1'b1;
            end
        end else begin
            r = f + 32'h0000_7FFF + FP32_W'(f[16]);
            fp32_to_bf16 = BF16_W'(r >> 16);
        end
`else
        fp32_to_bf16 = BF16_W'(f >> 16);
`endif
    endfunction

endpackage

// File: rtl/silu_wb_fifo.sv
// Show-ahead FIFO for packed words: head visible while not empty, zero when empty.
// A push when full is accepted only if a pop happens in the same cycle.
module silu_wb_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | i_pop);

    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/silu_result_packer.sv
// Packs pairs of 4-lane FP32 beats into 8xBF16 words behind a valid/ready FIFO.
// Word visible 1 cycle after its second beat; drops on full set sticky overflow (SILU_PACK_RNE_EN selects RNE).
module silu_result_packer
    import silu_pkg::*;
#(
    parameter int DATA_NUM   = 192,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stage_start,
    input  logic                    in_tvalid,
    input  logic [LANES*FP32_W-1:0] in_tdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [127:0]            out_tdata,
    output logic                    out_tlast,
    output logic                    batch_done,
    output logic                    overflow
);

    localparam int HALF_W = LANES * BF16_W;
    localparam int WORD_W = 2 * HALF_W;
    localparam int CNT_W  = $clog2(DATA_NUM);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_NUM - 1);

    logic              r_start_d;
    logic              r_phase;
    logic [HALF_W-1:0] r_half;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_overflow;
    logic              r_batch_done;

    logic              w_restart;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [HALF_W-1:0] w_conv;
    logic [WORD_W:0]   w_push_dat;
    logic [WORD_W:0]   w_head_dat;

    always_comb begin
        w_conv = '0;
        for (int l = 0; l < LANES; l++) begin
            w_conv[l*BF16_W +: BF16_W] = fp32_to_bf16(in_tdata[l*FP32_W +: FP32_W]);
        end
    end

    // Beats in the restart cycle belong to no batch and are discarded
    assign w_restart  = stage_start & ~r_start_d;
    assign w_accept   = in_tvalid & stage_start & ~w_restart;
    assign w_push     = w_accept & r_phase;
    assign w_pop      = out_tvalid & out_tready;
    assign w_drop     = w_push & w_full & ~w_pop;
    assign w_push_dat = {(r_beat_cnt == LAST_BEAT), w_conv, r_half};

    silu_wb_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (w_restart),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d    <= 1'b0;
            r_phase      <= 1'b0;
            r_half       <= '0;
            r_beat_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_batch_done <= 1'b0;
        end else begin
            r_start_d    <= stage_start;
            r_batch_done <= w_pop & w_head_dat[WORD_W];
            if (w_restart) begin
                r_phase    <= 1'b0;
                r_half     <= '0;
                r_beat_cnt <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_phase    <= ~r_phase;
                    r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + CNT_W'(1);
                    if (!r_phase) begin
                        r_half <= w_conv;
                    end
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign out_tvalid = ~w_empty;
    assign out_tdata  = w_head_dat[WORD_W-1:0];
    assign out_tlast  = w_head_dat[WORD_W];
    assign batch_done = r_batch_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_silu_result_packer.sv
// Directed bench for silu_result_packer: conversion, packing, batch framing, overflow and reset.
module tb_silu_result_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stage_start;
    logic         in_tvalid;
    logic [127:0] in_tdata;
    logic         out_tvalid;
    logic         out_tready;
    logic [127:0] out_tdata;
    logic         out_tlast;
    logic         batch_done;
    logic         overflow;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    silu_result_packer #(
        .DATA_NUM   (192),
        .FIFO_DEPTH (8),
        .FIFO_AW    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stage_start (stage_start),
        .in_tvalid   (in_tvalid),
        .in_tdata    (in_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .out_tdata   (out_tdata),
        .out_tlast   (out_tlast),
        .batch_done  (batch_done),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [127:0] d);
        in_tvalid = 1'b1;
        in_tdata  = d;
        tick();
        in_tvalid = 1'b0;
        in_tdata  = '0;
    endtask

    task automatic restart();
        stage_start = 1'b0;
        tick();
        stage_start = 1'b1;
        tick();
    endtask

    // lane j of beat i carries BF16 value i*4+j in its upper half
    function automatic logic [127:0] mk_beat(input int i);
        logic [127:0] b;
        for (int j = 0; j < 4; j++) b[j*32 +: 32] = {16'(i*4 + j), 16'h0000};
        return b;
    endfunction

    function automatic logic [127:0] exp_word(input int k);
        logic [127:0] w;
        for (int m = 0; m < 8; m++) w[m*16 +: 16] = 16'(8*k + m);
        return w;
    endfunction

    initial begin
        int bad, words, lasts, dones, first_done, n_drain;
        logic [127:0] t2_exp, last_w;

        rst_n = 1'b0; stage_start = 1'b0; in_tvalid = 1'b0; in_tdata = '0; out_tready = 1'b0;
        #3;
        check("rst_tvalid", out_tvalid, 0);
        check("rst_tdata", out_tdata, 0);
        check("rst_tlast", out_tlast, 0);
        check("rst_done", batch_done, 0);
        check("rst_ovf", overflow, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // beats while stage_start is low are ignored
        beat(mk_beat(0));
        beat(mk_beat(1));
        check("idle_ignored", out_tvalid, 0);

        // single pair of FP32 ones
        restart();
        out_tready = 1'b1;
        beat({4{32'h3F800000}});
        check("t1_first_beat_no_word", out_tvalid, 0);
        beat({4{32'h3F800000}});
        check("t1_tvalid", out_tvalid, 1);
        check("t1_tdata", out_tdata, {8{16'h3F80}});
        check("t1_tlast", out_tlast, 0);
        tick();
        check("t1_popped", out_tvalid, 0);

        // rounding cases then special values
`ifdef SILU_PACK_RNE_EN
        t2_exp = {16'hFF80, 16'h7FC0, 16'h7FC0, 16'h7F80, 16'h3F81, 16'h3F80, 16'h3F82, 16'h3F80};
`else
        t2_exp = {16'hFF80, 16'h7FC0, 16'h7F80, 16'h7F80, 16'h3F80, 16'h3F80, 16'h3F81, 16'h3F80};
`endif
        restart();
        beat({32'h3F808001, 32'h3F807FFF, 32'h3F818000, 32'h3F808000});
        beat({32'hFF800000, 32'h7FC00001, 32'h7F800001, 32'h7F800000});
        check("t2_conv", out_tdata, t2_exp);
        tick();

        // two back-to-back batches without restart
        restart();
        bad = 0; words = 0; lasts = 0; dones = 0; first_done = -1;
        for (int i = 0; i < 384; i++) begin
            beat(mk_beat(i));
            if (batch_done) begin
                dones++;
                if (first_done < 0) first_done = i;
            end
            if (out_tvalid !== ((i % 2) == 1)) bad++;
            if (out_tvalid) begin
                if (out_tdata !== exp_word(words)) bad++;
                if (out_tlast !== ((i % 192) == 191)) bad++;
                if (out_tlast) lasts++;
                words++;
            end
        end
        tick();
        if (batch_done) dones++;
        check("t3_word_errors", bad, 0);
        check("t3_words", words, 192);
        check("t3_tlasts", lasts, 2);
        check("t3_done_pulses", dones, 2);
        check("t3_first_done_at", first_done, 192);
        check("t3_ovf", overflow, 0);

        // stalled writer: 10 pushes into 8 entries
        restart();
        out_tready = 1'b0;
        for (int i = 0; i < 16; i++) beat(mk_beat(i));
        check("t4_full_no_ovf", overflow, 0);
        check("t4_full_valid", out_tvalid, 1);
        beat(mk_beat(16));
        beat(mk_beat(17));
        check("t4_ovf_9th", overflow, 1);
        beat(mk_beat(18));
        beat(mk_beat(19));
        check("t4_head_kept", out_tdata, exp_word(0));
        check("t4_ovf_sticky", overflow, 1);
        restart();
        check("t4_restart_empty", out_tvalid, 0);
        check("t4_restart_ovf", overflow, 0);

        // full with simultaneous push and pop
        out_tready = 1'b0;
        for (int i = 0; i < 17; i++) beat(mk_beat(i));
        out_tready = 1'b1;
        beat(mk_beat(17));
        out_tready = 1'b0;
        check("t5_no_ovf", overflow, 0);
        check("t5_head", out_tdata, exp_word(1));
        out_tready = 1'b1;
        n_drain = 0; last_w = '0;
        for (int c = 0; c < 20 && out_tvalid; c++) begin
            last_w = out_tdata;
            n_drain++;
            tick();
        end
        check("t5_drain_count", n_drain, 8);
        check("t5_drain_last", last_w, exp_word(8));

        // async reset mid-batch with a half-word pending
        restart();
        out_tready = 1'b0;
        for (int i = 0; i < 21; i++) beat(mk_beat(i));
        check("t6_pre_ovf", overflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", out_tvalid, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_done", batch_done, 0);
        check("t6_rst_tdata", out_tdata, 0);
        tick();
        rst_n = 1'b1;
        tick();
        beat(mk_beat(0));
        check("t6_phase0", out_tvalid, 0);
        beat(mk_beat(1));
        check("t6_word", out_tdata, exp_word(0));
        check("t6_tvalid", out_tvalid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/silu_result_packer.md
Name: silu_result_packer

Overview:
- Write-back end of the SiLU stage: consumes the 4-lane FP32 result stream (128-bit beats, valid-only, no backpressure) produced by the SiLU datapath.
- Converts each lane back to BF16 and pairs two consecutive beats into one 128-bit word of 8 BF16 values.
- Buffers words in a small FIFO and presents them on a valid/ready interface to the memory writer, with per-batch last/done signalling and overflow detection.

Parameters:
- DATA_NUM, 192: input beats per batch; must be even. Batch = DATA_NUM/2 output words.
- FIFO_DEPTH, 8: output FIFO entries; power of two.
- FIFO_AW, 3: log2(FIFO_DEPTH).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- stage_start  input  1  stage enable level; its rising edge starts a new batch
- in_tvalid  input  1  FP32 result beat valid
- in_tdata  input  128  4 x FP32, lane0 = [31:0] … lane3 = [127:96]
- out_tvalid  output  1  packed word available
- out_tready  input  1  writer accepts word
- out_tdata  output  128  8 x BF16; [63:0] = first beat lanes0-3, [127:64] = second beat lanes0-3
- out_tlast  output  1  marks the final word of a batch
- batch_done  output  1  one-cycle pulse when the tlast word is accepted
- overflow  output  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, async): all outputs 0; FIFO empty; beat counter, half-register and phase cleared.
- Restart (rising edge of stage_start, detected with a 1-cycle delayed copy):
  - Flushes FIFO pointers, beat counter, phase and half-register.
  - Clears overflow.
  - Beats arriving in the restart cycle are ignored.
- Beats sampled while stage_start is low are ignored.
- Conversion (combinational per lane):
  - Truncation: bf16 = fp32[31:16].
  - RNE variant: see Optional Feature.
- Packing:
  - phase 0: accepted beat → converted 64 bits stored in half-register; phase → 1.
  - phase 1: word {conv(beat), half} is pushed; phase → 0.
- Beat counter: 0..DATA_NUM-1, increments per accepted beat, wraps to 0 after beat DATA_NUM-1.
  - out_tlast is stored alongside a word when it is pushed on beat DATA_NUM-1.
- Latency: the word appears on out_tdata with out_tvalid=1 in the cycle after the second beat is sampled, provided the FIFO was empty.
- FIFO: show-ahead; out_tvalid = !empty; out_tdata and out_tlast reflect the head entry; pop on out_tvalid & out_tready.
- Boundary conditions:
  - Full and push without pop: word dropped, overflow set to 1 and held.
  - Full and push with pop in the same cycle: push succeeds, count unchanged.
  - Empty and pop: impossible, because out_tvalid is 0.
  - Dropped tlast word: batch_done never fires for that batch; overflow flags it.
  - Pointers wrap modulo FIFO_DEPTH; count width is FIFO_AW+1.
- batch_done: registered, high the cycle after the handshake on a tlast word; low otherwise.
- Reset mid-batch: immediate clear; no partial word is ever emitted.

Optional Feature:
- Macro: SILU_PACK_RNE_EN.
- Defined — per lane:
  - exponent == 8'hFF: bf16 = fp32[31:16], with bit 6 forced to 1 if fp32[22:0] != 0 (quiet NaN, Inf preserved).
  - otherwise: bf16 = (fp32 + 16'h7FFF + fp32[16])[31:16] (round to nearest even; overflow to Inf is allowed).
- Undefined: pure truncation for every lane.

Decomposition:
- Shared package silu_pkg:
  - FP32_W=32, BF16_W=16, LANES=4, FP32_ONE=32'h3F800000.
  - fp32_to_bf16 function (both variants under the macro).
- One natural sub-module: silu_wb_fifo — synchronous show-ahead FIFO, width 129 (data + last), depth FIFO_DEPTH, with full/empty outputs.

Test Plan:
- Single pair of beats, all lanes 32'h3F800000, out_tready=1 → one word of 128'h3F80 x8, out_tvalid high 1 cycle after the second beat, out_tlast=0.
- RNE defined, lanes 3F808000 / 3F818000 / 3F807FFF / 3F808001 → 3F80 / 3F82 / 3F80 / 3F81; undefined → 3F80 / 3F81 / 3F80 / 3F80.
- RNE defined, lanes 7F800000 / 7F800001 / 7FC00001 / FF800000 → 7F80 / 7FC0 / 7FC0 / FF80.
- 192 continuous beats, out_tready=1 → exactly 96 words; out_tlast only on word 96; batch_done one pulse; overflow=0; second batch continues the pattern without restart.
- out_tready=0, 20 beats with depth 8 → 8 words held, overflow=1 on the 9th push; stage_start low→high then → FIFO empty, overflow=0.
- rst_n pulsed low after beat 3 → out_tvalid, batch_done, overflow immediately 0; the next beat is treated as phase 0.
